// File: rtl/alu_sequencer.sv
// alu_sequencer: one-at-a-time ADD/SUB (1 cycle), shift-add MUL and restoring DIV (DW cycles).
// Define ALU_OVF_ERROR_EN to report arithmetic overflow on o_alu_error; divide-by-zero always does.
module alu_sequencer #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_flush,
  input  logic [DATA_WIDTH-1:0] i_alu_input_a,
  input  logic [DATA_WIDTH-1:0] i_alu_input_b,
  input  logic [1:0]            i_alu_input_op,
  input  logic                  i_alu_input_signed,
  input  logic                  i_alu_input_valid,
  output logic                  o_alu_input_ready,
  output logic [DATA_WIDTH-1:0] o_alu_result,
  output logic                  o_alu_error,
  output logic                  o_alu_result_valid,
  input  logic                  i_alu_result_ready,
  output logic                  o_busy,
  output logic [2:0]            o_dbg_state
);
  localparam int DW  = DATA_WIDTH;
  localparam int CW  = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [DW-1:0]   ONE_DW  = DW'(1);
  localparam logic [2*DW-1:0] ONE_2DW = (2*DW)'(1);
`ifdef ALU_OVF_ERROR_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_ADDSUB, S_MUL, S_DIV, S_FIXUP, S_DONE
  } state_t;

  // Both handshakes transfer on a clk edge where valid && ready are high; the
  // producer holds its payload stable until that edge.
  state_t           state_q, state_d;
  logic [DW-1:0]    a_q, a_d, b_q, b_d;
  logic             op_lsb_q, op_lsb_d;   // SUB in ADDSUB, DIV in FIXUP
  logic             sgn_q, sgn_d, neg_q, neg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*DW-1:0]  acc_q, acc_d;
  logic [DW-1:0]    result_q, result_d;
  logic             error_q, error_d;

  logic             accept;
  logic [DW-1:0]    mag_a, mag_b;
  logic [DW:0]      sum_ext, mul_sum, div_trial;
  logic             addsub_ovf, mul_ovf, div_ovf;
  logic [2*DW-1:0]  mul_next, div_next, mul_full;
  logic [DW-1:0]    quo, div_res;

  assign o_alu_input_ready  = (state_q == S_IDLE) && !i_flush;
  assign o_alu_result_valid = (state_q == S_DONE);
  assign o_busy             = (state_q != S_IDLE);
  assign o_alu_result       = result_q;
  assign o_alu_error        = error_q;
  assign o_dbg_state        = state_q;
  assign accept             = i_alu_input_valid && o_alu_input_ready;

  always_comb begin
    mag_a = (i_alu_input_signed && i_alu_input_a[DW-1]) ? (~i_alu_input_a + ONE_DW) : i_alu_input_a;
    mag_b = (i_alu_input_signed && i_alu_input_b[DW-1]) ? (~i_alu_input_b + ONE_DW) : i_alu_input_b;

    sum_ext = op_lsb_q ? ({1'b0, a_q} - {1'b0, b_q}) : ({1'b0, a_q} + {1'b0, b_q});
    if (sgn_q)
      addsub_ovf = (op_lsb_q ? (a_q[DW-1] != b_q[DW-1]) : (a_q[DW-1] == b_q[DW-1]))
                   && (sum_ext[DW-1] != a_q[DW-1]);
    else
      addsub_ovf = sum_ext[DW];

    mul_sum  = {1'b0, acc_q[2*DW-1:DW]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_next = {mul_sum, acc_q[DW-1:1]};

    // Trial-subtract the divisor from the shifted partial remainder; a borrow restores it.
    div_trial = acc_q[2*DW-1:DW-1] - {1'b0, b_q};
    if (div_trial[DW])
      div_next = {acc_q[2*DW-2:0], 1'b0};
    else
      div_next = {div_trial[DW-1:0], acc_q[DW-2:0], 1'b1};

    mul_full = neg_q ? (~acc_q + ONE_2DW) : acc_q;
    mul_ovf  = sgn_q ? (mul_full[2*DW-1:DW] != {DW{mul_full[DW-1]}})
                     : (mul_full[2*DW-1:DW] != '0);
    quo      = acc_q[DW-1:0];
    div_res  = neg_q ? (~quo + ONE_DW) : quo;
    div_ovf  = sgn_q && !neg_q && quo[DW-1];
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_lsb_d = op_lsb_q;
    sgn_d    = sgn_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    error_d  = error_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_lsb_d = i_alu_input_op[0];
          sgn_d    = i_alu_input_signed;
          neg_d    = i_alu_input_signed && (i_alu_input_a[DW-1] ^ i_alu_input_b[DW-1]);
          cnt_d    = CW'(DW - 1);
          case (i_alu_input_op)
            2'b10: begin
              a_d     = mag_a;
              acc_d   = {{DW{1'b0}}, mag_b};
              state_d = S_MUL;
            end
            2'b11: begin
              if (i_alu_input_b == '0) begin
                result_d = '0;
                error_d  = 1'b1;
                state_d  = S_DONE;
              end else begin
                b_d     = mag_b;
                acc_d   = {{DW{1'b0}}, mag_a};
                state_d = S_DIV;
              end
            end
            default: begin
              a_d     = i_alu_input_a;
              b_d     = i_alu_input_b;
              state_d = S_ADDSUB;
            end
          endcase
        end
      end
      S_ADDSUB: begin
        result_d = sum_ext[DW-1:0];
        error_d  = OVF_EN && addsub_ovf;
        state_d  = S_DONE;
      end
      S_MUL, S_DIV: begin
        acc_d = (state_q == S_MUL) ? mul_next : div_next;
        if (cnt_q == '0) state_d = S_FIXUP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_FIXUP: begin
        result_d = op_lsb_q ? div_res : mul_full[DW-1:0];
        error_d  = OVF_EN && (op_lsb_q ? div_ovf : mul_ovf);
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (i_alu_result_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (i_flush) begin
      state_d  = S_IDLE;
      result_d = '0;
      error_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_lsb_q <= 1'b0;
      sgn_q    <= 1'b0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_lsb_q <= op_lsb_d;
      sgn_q    <= sgn_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer (DW=16): directed vector table, multi-cycle corner sequences,
// and random operations checked against an integer-arithmetic reference model.
module tb_alu_sequencer;
  localparam int DW = 16;
`ifdef ALU_OVF_ERROR_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_flush = 1'b0;
  logic [DW-1:0] i_alu_input_a = '0;
  logic [DW-1:0] i_alu_input_b = '0;
  logic [1:0]    i_alu_input_op = '0;
  logic          i_alu_input_signed = 1'b0;
  logic          i_alu_input_valid = 1'b0;
  logic          o_alu_input_ready;
  logic [DW-1:0] o_alu_result;
  logic          o_alu_error;
  logic          o_alu_result_valid;
  logic          i_alu_result_ready = 1'b0;
  logic          o_busy;
  logic [2:0]    o_dbg_state;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic        sgn;
    logic [15:0] res;
    logic        ovf;
    logic        div0;
  } vec_t;
  vec_t vecs[$];

  alu_sequencer #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .i_flush(i_flush),
    .i_alu_input_a(i_alu_input_a), .i_alu_input_b(i_alu_input_b),
    .i_alu_input_op(i_alu_input_op), .i_alu_input_signed(i_alu_input_signed),
    .i_alu_input_valid(i_alu_input_valid), .o_alu_input_ready(o_alu_input_ready),
    .o_alu_result(o_alu_result), .o_alu_error(o_alu_error),
    .o_alu_result_valid(o_alu_result_valid), .i_alu_result_ready(i_alu_result_ready),
    .o_busy(o_busy), .o_dbg_state(o_dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: exact integer result, wrapped to 16 bits; overflow = out of representable range.
  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [1:0] op, input logic sgn);
    longint x, y, r;
    bit ovf;
    x = sgn ? longint'($signed(a)) : longint'(a);
    y = sgn ? longint'($signed(b)) : longint'(b);
    if (op == 2'd3 && b == 16'h0) return {1'b1, 16'h0000};
    case (op)
      2'd0:    r = x + y;
      2'd1:    r = x - y;
      2'd2:    r = x * y;
      default: r = x / y;
    endcase
    ovf = sgn ? (r < -32768 || r > 32767) : (r < 0 || r > 65535);
    return {OVF_EN && ovf, r[15:0]};
  endfunction

  function automatic int lat_of(input logic [15:0] b, input logic [1:0] op);
    if (op == 2'd3 && b == 16'h0) return 1;
    return op[1] ? DW + 2 : 2;
  endfunction

  // Waits (bounded) for ready, presents the op, returns sampled just after the accept edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                       input logic sgn, input string tag);
    int n = 0;
    while (!o_alu_input_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({tag, " ready"}, o_alu_input_ready, 1);
    i_alu_input_a = a; i_alu_input_b = b; i_alu_input_op = op; i_alu_input_signed = sgn;
    i_alu_input_valid = 1'b1;
    @(posedge clk); #1;
    i_alu_input_valid = 1'b0;
  endtask

  // Counts accept-to-valid edges (accept edge is 1); input ready must stay low meanwhile.
  task automatic wait_valid(output int n, output bit ready_bad);
    n = 1; ready_bad = 0;
    while (!o_alu_result_valid && n < 40) begin
      if (o_alu_input_ready || !o_busy) ready_bad = 1;
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                        input logic sgn, input logic [15:0] exp_res, input logic exp_err,
                        input int exp_lat, input string tag);
    int n;
    bit rb;
    issue(a, b, op, sgn, tag);
    wait_valid(n, rb);
    check({tag, " latency"}, n, exp_lat);
    check({tag, " result"}, o_alu_result, exp_res);
    check({tag, " error"}, o_alu_error, exp_err);
    check({tag, " ready low while busy"}, {rb, o_alu_input_ready}, 0);
    i_alu_result_ready = 1'b1;
    @(posedge clk); #1;
    i_alu_result_ready = 1'b0;
    check({tag, " idle after handshake"}, {o_busy, o_alu_result_valid}, 0);
  endtask

  initial begin
    int n;
    bit rb;
    logic [15:0] ra, rbv, held;
    logic [1:0]  rop;
    logic        rs;
    logic [16:0] m;

    // Reset state
    #1;
    check("reset result", o_alu_result, 0);
    check("reset error", o_alu_error, 0);
    check("reset valid", o_alu_result_valid, 0);
    check("reset busy", o_busy, 0);
    check("reset ready", o_alu_input_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    //            a        b        op    sgn   res      ovf   div0
    vecs.push_back('{16'h1234, 16'h0001, 2'd0, 1'b0, 16'h1235, 1'b0, 1'b0});
    vecs.push_back('{16'hFFFD, 16'h0007, 2'd2, 1'b1, 16'hFFEB, 1'b0, 1'b0});
    vecs.push_back('{16'h0064, 16'h0000, 2'd3, 1'b0, 16'h0000, 1'b0, 1'b1});
    vecs.push_back('{16'hFFF9, 16'h0002, 2'd3, 1'b1, 16'hFFFD, 1'b0, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0001, 2'd0, 1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'h8000, 16'hFFFF, 2'd3, 1'b1, 16'h8000, 1'b1, 1'b0});
    vecs.push_back('{16'h0005, 16'h0007, 2'd1, 1'b0, 16'hFFFE, 1'b1, 1'b0});
    vecs.push_back('{16'h7FFF, 16'h0001, 2'd0, 1'b1, 16'h8000, 1'b1, 1'b0});
    vecs.push_back('{16'h8000, 16'h0001, 2'd1, 1'b1, 16'h7FFF, 1'b1, 1'b0});
    vecs.push_back('{16'h0100, 16'h0100, 2'd2, 1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 2'd2, 1'b1, 16'h0001, 1'b0, 1'b0});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 2'd2, 1'b0, 16'h0001, 1'b1, 1'b0});
    vecs.push_back('{16'h8000, 16'hFFFF, 2'd2, 1'b1, 16'h8000, 1'b1, 1'b0});
    vecs.push_back('{16'h8000, 16'h0001, 2'd2, 1'b1, 16'h8000, 1'b0, 1'b0});
    vecs.push_back('{16'h00C8, 16'h0007, 2'd3, 1'b0, 16'h001C, 1'b0, 1'b0});
    vecs.push_back('{16'hFFF9, 16'h0002, 2'd3, 1'b0, 16'h7FFC, 1'b0, 1'b0});
    vecs.push_back('{16'h0007, 16'hFFFE, 2'd3, 1'b1, 16'hFFFD, 1'b0, 1'b0});

    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].sgn, vecs[i].res,
             vecs[i].div0 | (OVF_EN & vecs[i].ovf), lat_of(vecs[i].b, vecs[i].op),
             $sformatf("vec%0d", i));

    // Backpressure: result held 5 cycles in DONE while a second request waits.
    issue(16'h0003, 16'h0005, 2'd2, 1'b0, "bp");
    wait_valid(n, rb);
    check("bp latency", n, DW + 2);
    held = o_alu_result;
    i_alu_input_a = 16'h0001; i_alu_input_b = 16'h0001; i_alu_input_op = 2'd0;
    i_alu_input_valid = 1'b1;
    rb = 0;
    for (int k = 0; k < 5; k++) begin
      if (o_alu_result !== 16'h000F || o_alu_error !== 1'b0 || !o_alu_result_valid || o_alu_input_ready)
        rb = 1;
      @(posedge clk); #1;
    end
    check("bp held stable", rb, 0);
    check("bp held value", o_alu_result, 16'h000F);
    i_alu_result_ready = 1'b1;
    @(posedge clk); #1;
    i_alu_result_ready = 1'b0;
    i_alu_input_valid  = 1'b0;
    check("bp idle after ready", {o_busy, o_alu_input_ready}, 2'b01);
    @(posedge clk); #1;
    check("bp second not accepted", o_busy, 0);
    check("bp result unchanged", o_alu_result, held);

    // Flush on the 8th MUL cycle, then an immediate ADD.
    issue(16'h1234, 16'h0011, 2'd2, 1'b0, "flush");
    repeat (7) begin @(posedge clk); #1; end
    i_flush = 1'b1;
    #1;
    check("flush gates ready", o_alu_input_ready, 0);
    @(posedge clk); #1;
    i_flush = 1'b0;
    check("flush idle", {o_busy, o_alu_result_valid}, 0);
    check("flush result cleared", {o_alu_error, o_alu_result}, 0);
    run_op(16'h0002, 16'h0003, 2'd0, 1'b0, 16'h0005, 1'b0, 2, "post-flush add");
    rb = 0;
    repeat (20) begin
      if (o_alu_result_valid) rb = 1;
      @(posedge clk); #1;
    end
    check("flushed mul never valid", rb, 0);

    // Flush wins over the DONE handshake and clears the held result.
    issue(16'h0064, 16'h0000, 2'd3, 1'b0, "flush-done");
    i_flush = 1'b1; i_alu_result_ready = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0; i_alu_result_ready = 1'b0;
    check("flush in done", {o_alu_result_valid, o_alu_error, o_alu_result}, 0);

    // Asynchronous reset mid-DIV.
    issue(16'h1000, 16'h0003, 2'd3, 1'b0, "rst");
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("mid-op reset idle", {o_busy, o_alu_result_valid, o_alu_input_ready}, 3'b001);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Random operations against the reference model.
    for (int i = 0; i < 150; i++) begin
      ra  = 16'($urandom_range(0, 65535));
      case ($urandom_range(0, 7))
        0:       rbv = 16'h0000;
        1:       rbv = 16'($urandom_range(0, 7));
        2:       rbv = 16'hFFFF;
        default: rbv = 16'($urandom_range(0, 65535));
      endcase
      rop = 2'($urandom_range(0, 3));
      rs  = 1'($urandom_range(0, 1));
      m   = model(ra, rbv, rop, rs);
      run_op(ra, rbv, rop, rs, m[15:0], m[16], lat_of(rbv, rop), $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
